// File: rtl/fifo_rr_sched.sv
// Round-robin packet scheduler: grants one FWFT ingress FIFO per packet and
// forwards its words through a registered valid/ready output stage.
module fifo_rr_sched #(
  parameter int PORT_NUM    = 2,
  parameter int DATA_W      = 32,
  parameter int MAX_PKT_LEN = 256,
  parameter int CNT_W       = 9
) (
  input  logic                       glb_clk,
  input  logic                       glb_areset,
  input  logic [PORT_NUM-1:0]        fifo_empty,
  input  logic [PORT_NUM*DATA_W-1:0] fifo_dout,
  input  logic [PORT_NUM-1:0]        fifo_eop,
  output logic [PORT_NUM-1:0]        fifo_rd_en,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_eop,
  input  logic                       out_ready,
  output logic [7:0]                 fifo_sel_code,
  output logic                       pkt_trunc
);

  localparam int IDX_W = $clog2(PORT_NUM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_PKT_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_NUM - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, gnt, gnt_nxt, arb_idx;
  logic                arb_hit;
  logic [CNT_W-1:0]    word_cnt;
  logic [DATA_W-1:0]   dout_arr [PORT_NUM];
  logic [DATA_W-1:0]   head_data;
  logic                head_empty, head_eop;
  logic                pop, trunc, pkt_end;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_unpack
    assign dout_arr[i] = fifo_dout[i*DATA_W +: DATA_W];
  end

  assign head_data  = dout_arr[gnt];
  assign head_empty = fifo_empty[gnt];
  assign head_eop   = fifo_eop[gnt];

  // First requester at or after rr_ptr, wrapping modulo PORT_NUM.
  always_comb begin
    int idx;
    arb_hit = 1'b0;
    arb_idx = '0;
    idx     = 0;
    for (int k = 0; k < PORT_NUM; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= PORT_NUM) idx = idx - PORT_NUM;
      if (!arb_hit && !fifo_empty[idx]) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(idx);
      end
    end
  end

  assign pop     = (state == XFER) && !head_empty && (!out_valid || out_ready);
  assign trunc   = pop && !head_eop && (word_cnt == LAST_CNT);
  assign pkt_end = pop && (head_eop || trunc);
  assign gnt_nxt = (state == IDLE && arb_hit) ? arb_idx : gnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_hit) state_nxt = XFER;
      XFER:    if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the default assignment first keeps this combinational block
  // latch-free when no pop is taking place.
  always_comb begin
    fifo_rd_en = '0;
    if (pop) fifo_rd_en[gnt] = 1'b1;
  end

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      rr_ptr        <= '0;
      gnt           <= '0;
      word_cnt      <= '0;
      fifo_sel_code <= '0;
      pkt_trunc     <= 1'b0;
    end else begin
      gnt           <= gnt_nxt;
      pkt_trunc     <= trunc;
      fifo_sel_code <= (state_nxt == XFER) ? (8'd128 + 8'(gnt_nxt)) : 8'd0;
      if (state == IDLE && arb_hit) word_cnt <= '0;
      else if (pop)                 word_cnt <= word_cnt + 1'b1;
      if (pkt_end) rr_ptr <= (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
    end
  end

  // Output stage holds its word while the consumer stalls.
  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eop   <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_eop   <= head_eop || trunc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: queue-backed FWFT FIFOs, a cycle table, corner
// sequences and a packet-level round-robin reference model under random ready.
module tb_fifo_rr_sched;

  localparam int PORT_NUM    = 3;
  localparam int DATA_W      = 16;
  localparam int MAX_PKT_LEN = 4;
  localparam int CNT_W       = 3;

  typedef logic [DATA_W:0] word_t;  // {eop, data}

  typedef struct {
    bit                  load;
    logic [DATA_W-1:0]   base;
    bit                  ready;
    logic [PORT_NUM-1:0] rd;
    bit                  v;
    logic [DATA_W-1:0]   d;
    bit                  e;
    logic [7:0]          sel;
  } vec_t;

  logic                       glb_clk = 1'b0;
  logic                       glb_areset;
  logic [PORT_NUM-1:0]        fifo_empty;
  logic [PORT_NUM*DATA_W-1:0] fifo_dout;
  logic [PORT_NUM-1:0]        fifo_eop;
  logic [PORT_NUM-1:0]        fifo_rd_en;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic                       out_eop;
  logic                       out_ready;
  logic [7:0]                 fifo_sel_code;
  logic                       pkt_trunc;

  fifo_rr_sched #(
    .PORT_NUM(PORT_NUM), .DATA_W(DATA_W), .MAX_PKT_LEN(MAX_PKT_LEN), .CNT_W(CNT_W)
  ) dut (
    .glb_clk(glb_clk), .glb_areset(glb_areset),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_eop(fifo_eop),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_eop(out_eop), .out_ready(out_ready), .fifo_sel_code(fifo_sel_code),
    .pkt_trunc(pkt_trunc)
  );

  always #5 glb_clk = ~glb_clk;

  word_t q [PORT_NUM][$];
  word_t acc_q[$];
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    trunc_cnt = 0;

  logic [PORT_NUM-1:0] obs_rd;
  logic                obs_valid, obs_ready, obs_eop, obs_trunc;
  logic [DATA_W-1:0]   obs_data;
  logic [7:0]          obs_sel;
  bit                  prev_stall = 1'b0;
  word_t               prev_word;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < PORT_NUM; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      if (q[i].size() != 0) {fifo_eop[i], fifo_dout[i*DATA_W +: DATA_W]} = q[i][0];
      else                  {fifo_eop[i], fifo_dout[i*DATA_W +: DATA_W]} = '0;
    end
  endfunction

  function automatic void push_pkt(int p, logic [DATA_W-1:0] base, int len, bit eop_last);
    for (int k = 0; k < len; k++)
      q[p].push_back({eop_last && (k == len - 1), base + DATA_W'(k)});
    refresh();
  endfunction

  function automatic bit all_empty();
    bit r = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) if (q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  function automatic int idx_of(logic [PORT_NUM-1:0] v);
    int r = -1;
    for (int i = 0; i < PORT_NUM; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Sample on the falling edge, then advance to just after the next rising
  // edge and pop whatever the DUT strobed.
  task automatic cycle();
    @(negedge glb_clk);
    obs_rd    = fifo_rd_en;
    obs_valid = out_valid;
    obs_ready = out_ready;
    obs_data  = out_data;
    obs_eop   = out_eop;
    obs_sel   = fifo_sel_code;
    obs_trunc = pkt_trunc;
    if (!glb_areset) begin
      check("rd_en_onehot", int'($countones(obs_rd) <= 1), 1);
      if (obs_rd != '0) check("sel_vs_rd", int'(obs_sel), 128 + idx_of(obs_rd));
      if (prev_stall) begin
        check("hold_valid", int'(obs_valid), 1);
        check("hold_word", int'({obs_eop, obs_data}), int'(prev_word));
      end
      prev_stall = obs_valid && !obs_ready;
      prev_word  = {obs_eop, obs_data};
      if (obs_valid && obs_ready) acc_q.push_back({obs_eop, obs_data});
      if (obs_trunc) trunc_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge glb_clk);
    #1;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (obs_rd[i]) begin
        check("pop_nonempty", int'(q[i].size() != 0), 1);
        if (q[i].size() != 0) void'(q[i].pop_front());
      end
    end
    refresh();
  endtask

  task automatic outputs_zero(string tag);
    check({tag, "_rd_en"}, int'(fifo_rd_en), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"},  int'(out_data), 0);
    check({tag, "_eop"},   int'(out_eop), 0);
    check({tag, "_sel"},   int'(fifo_sel_code), 0);
    check({tag, "_trunc"}, int'(pkt_trunc), 0);
  endtask

  task automatic do_reset();
    glb_areset = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < PORT_NUM; i++) q[i].delete();
    refresh();
    cycle();
    cycle();
    acc_q.delete();
    exp_q.delete();
    trunc_cnt  = 0;
    glb_areset = 1'b0;
  endtask

  task automatic drain(string name, int max_cyc, bit rnd);
    bit done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cycle();
      done = all_empty() && !obs_valid && (obs_sel == 8'd0) && (obs_rd == '0);
    end
    check({name, "_done"}, int'(done), 1);
    out_ready = 1'b1;
  endtask

  task automatic cmp_stream(string name);
    check({name, "_len"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      check($sformatf("%s_word%0d", name, i), int'(acc_q[i]), int'(exp_q[i]));
  endtask

  // Packet-level model: whole packets taken in round-robin order from the
  // preloaded queues, cut at MAX_PKT_LEN words.
  task automatic build_model(output int exp_trunc);
    word_t mq [PORT_NUM][$];
    int    rr = 0;
    exp_trunc = 0;
    for (int p = 0; p < PORT_NUM; p++) mq[p] = q[p];
    forever begin
      int sel = -1;
      int cnt = 0;
      for (int k = 0; k < PORT_NUM; k++)
        if (sel < 0 && mq[(rr + k) % PORT_NUM].size() != 0) sel = (rr + k) % PORT_NUM;
      if (sel < 0) break;
      while (mq[sel].size() != 0) begin
        word_t w = mq[sel].pop_front();
        cnt++;
        if (!w[DATA_W] && cnt == MAX_PKT_LEN) begin
          w[DATA_W] = 1'b1;
          exp_trunc++;
        end
        exp_q.push_back(w);
        if (w[DATA_W]) break;
      end
      rr = (sel + 1) % PORT_NUM;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[16];
    logic [7:0] alt_exp[13];
    int exp_trunc;

    tv[0]  = '{1'b1, 16'h1000, 1'b1, 3'b000, 1'b0, 16'h0000, 1'b0, 8'd0};
    tv[1]  = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b0, 16'h0000, 1'b0, 8'd128};
    tv[2]  = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b1, 16'h1000, 1'b0, 8'd128};
    tv[3]  = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b1, 16'h1001, 1'b0, 8'd128};
    tv[4]  = '{1'b0, 16'h0000, 1'b1, 3'b000, 1'b1, 16'h1002, 1'b1, 8'd0};
    tv[5]  = '{1'b0, 16'h0000, 1'b1, 3'b000, 1'b0, 16'h0000, 1'b0, 8'd0};
    tv[6]  = '{1'b1, 16'h2000, 1'b1, 3'b000, 1'b0, 16'h0000, 1'b0, 8'd0};
    tv[7]  = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b0, 16'h0000, 1'b0, 8'd128};
    tv[8]  = '{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h2000, 1'b0, 8'd128};
    tv[9]  = '{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h2000, 1'b0, 8'd128};
    tv[10] = '{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h2000, 1'b0, 8'd128};
    tv[11] = '{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h2000, 1'b0, 8'd128};
    tv[12] = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b1, 16'h2000, 1'b0, 8'd128};
    tv[13] = '{1'b0, 16'h0000, 1'b1, 3'b001, 1'b1, 16'h2001, 1'b0, 8'd128};
    tv[14] = '{1'b0, 16'h0000, 1'b1, 3'b000, 1'b1, 16'h2002, 1'b1, 8'd0};
    tv[15] = '{1'b0, 16'h0000, 1'b1, 3'b000, 1'b0, 16'h0000, 1'b0, 8'd0};
    alt_exp = '{8'd0, 8'd128, 8'd128, 8'd0, 8'd129, 8'd129, 8'd0,
                8'd128, 8'd128, 8'd0, 8'd129, 8'd129, 8'd0};

    glb_areset = 1'b1;
    out_ready  = 1'b1;
    refresh();
    #1;
    outputs_zero("por");
    do_reset();

    // Single packet, then a 4-cycle stall after the first word.
    for (int i = 0; i < 16; i++) begin
      out_ready = tv[i].ready;
      if (tv[i].load) push_pkt(0, tv[i].base, 3, 1'b1);
      cycle();
      check($sformatf("tbl%0d_rd_en", i), int'(obs_rd), int'(tv[i].rd));
      check($sformatf("tbl%0d_valid", i), int'(obs_valid), int'(tv[i].v));
      check($sformatf("tbl%0d_sel", i), int'(obs_sel), int'(tv[i].sel));
      if (tv[i].v) begin
        check($sformatf("tbl%0d_data", i), int'(obs_data), int'(tv[i].d));
        check($sformatf("tbl%0d_eop", i), int'(obs_eop), int'(tv[i].e));
      end
    end

    // Reset mid-packet while port 1 holds the grant (rr_ptr is 1 here).
    push_pkt(0, 16'h4000, 3, 1'b1);
    push_pkt(1, 16'h4100, 3, 1'b1);
    cycle();
    cycle();
    cycle();
    check("rst_pre_valid", int'(obs_valid), 1);
    check("rst_pre_sel", int'(obs_sel), 129);
    #2 glb_areset = 1'b1;
    #1 outputs_zero("rst_mid");
    cycle();
    acc_q.delete();
    trunc_cnt  = 0;
    glb_areset = 1'b0;
    cycle();
    cycle();
    check("rst_next_grant", int'(obs_sel), 128);
    drain("rst", 100, 1'b0);
    exp_q.delete();
    exp_q.push_back({1'b0, 16'h4000});
    exp_q.push_back({1'b0, 16'h4001});
    exp_q.push_back({1'b1, 16'h4002});
    exp_q.push_back({1'b1, 16'h4102});
    cmp_stream("rst");

    // Two ports with back-to-back 2-word packets alternate grants.
    do_reset();
    push_pkt(0, 16'h5000, 2, 1'b1);
    push_pkt(0, 16'h5010, 2, 1'b1);
    push_pkt(1, 16'h5100, 2, 1'b1);
    push_pkt(1, 16'h5110, 2, 1'b1);
    for (int i = 0; i < 13; i++) begin
      cycle();
      check($sformatf("alt%0d_sel", i), int'(obs_sel), int'(alt_exp[i]));
    end
    drain("alt", 50, 1'b0);
    exp_q.push_back({1'b0, 16'h5000});
    exp_q.push_back({1'b1, 16'h5001});
    exp_q.push_back({1'b0, 16'h5100});
    exp_q.push_back({1'b1, 16'h5101});
    exp_q.push_back({1'b0, 16'h5010});
    exp_q.push_back({1'b1, 16'h5011});
    exp_q.push_back({1'b0, 16'h5110});
    exp_q.push_back({1'b1, 16'h5111});
    cmp_stream("alt");

    // Port 1 runs past MAX_PKT_LEN; port 0 arrives during the packet.
    do_reset();
    push_pkt(1, 16'h3100, 6, 1'b0);
    push_pkt(1, 16'h3106, 1, 1'b1);
    cycle();
    push_pkt(0, 16'h3000, 2, 1'b1);
    cycle();
    cycle();
    cycle();
    cycle();
    check("trc_c4_trunc", int'(obs_trunc), 0);
    check("trc_c4_rd", int'(obs_rd), 2);
    cycle();
    check("trc_c5_trunc", int'(obs_trunc), 1);
    check("trc_c5_valid", int'(obs_valid), 1);
    check("trc_c5_word", int'({obs_eop, obs_data}), int'({1'b1, 16'h3103}));
    check("trc_c5_sel", int'(obs_sel), 0);
    drain("trc", 100, 1'b0);
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 16'h3100 + 16'(k)});
    exp_q.push_back({1'b0, 16'h3000});
    exp_q.push_back({1'b1, 16'h3001});
    exp_q.push_back({1'b0, 16'h3104});
    exp_q.push_back({1'b0, 16'h3105});
    exp_q.push_back({1'b1, 16'h3106});
    cmp_stream("trc");
    check("trc_pulses", trunc_cnt, 1);

    // Granted port runs dry mid-packet while port 0 waits.
    do_reset();
    push_pkt(1, 16'h6100, 2, 1'b0);
    cycle();
    push_pkt(0, 16'h6000, 2, 1'b1);
    cycle();
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("dry%0d_sel", i), int'(obs_sel), 129);
      check($sformatf("dry%0d_rd", i), int'(obs_rd), 0);
    end
    push_pkt(1, 16'h6102, 1, 1'b1);
    drain("dry", 100, 1'b0);
    exp_q.push_back({1'b0, 16'h6100});
    exp_q.push_back({1'b0, 16'h6101});
    exp_q.push_back({1'b1, 16'h6102});
    exp_q.push_back({1'b0, 16'h6000});
    exp_q.push_back({1'b1, 16'h6001});
    cmp_stream("dry");

    // Random packet mixes under random backpressure.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int p = 0; p < PORT_NUM; p++) begin
        int npkt = $urandom_range(0, 3);
        for (int n = 0; n < npkt; n++) begin
          int len = $urandom_range(1, 7);
          for (int k = 0; k < len; k++)
            q[p].push_back({k == len - 1, 4'(p), 12'($urandom)});
        end
      end
      refresh();
      build_model(exp_trunc);
      drain($sformatf("rnd%0d", r), 4000, 1'b1);
      cmp_stream($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_trunc", r), trunc_cnt, exp_trunc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
